// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER core: fetch / execute / load writeback plus interrupt entry.
// Latency: non-load 2+MEM_WAIT cycles, load 3+2*MEM_WAIT cycles, taken interrupt +1 cycle.
// Backpressure: none; memory latency is a fixed MEM_WAIT stall, and the FSM never waits on a handshake.
//
// Ports:
//   CLK, RST_N           clock and asynchronous active-low reset
//   CU_OPCODE, FUNC3     fields of the instruction register
//   IRQ, IRQ_EN          level interrupt lines (edge-captured here) and global enable
//   PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE   datapath enables
//   INT_TAKEN            interrupt entry, forces the decoder's PC_SOURCE to the trap vector
//   IRQ_ID, IRQ_ACK      lowest pending line index and one-hot acknowledge in the interrupt cycle
module otter_cu_fsm #(
  parameter int NUM_IRQ  = 4,
  parameter int MEM_WAIT = 1,
  localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [6:0]         CU_OPCODE,
  input  logic [2:0]         FUNC3,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               IRQ_EN,
  output logic               PC_WRITE,
  output logic               REG_WRITE,
  output logic               MEM_RDEN1,
  output logic               MEM_RDEN2,
  output logic               MEM_WE2,
  output logic               CSR_WE,
  output logic               INT_TAKEN,
  output logic [ID_W-1:0]    IRQ_ID,
  output logic [NUM_IRQ-1:0] IRQ_ACK
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_INTR  = 2'd3;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [2:0]         cnt;
  logic [2:0]         cnt_nxt;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] irq_rise;
  logic               wait_done;
  logic               irq_go;
  logic               is_load;

  assign wait_done = (cnt == WAIT_LAST);
  assign irq_go    = (|pending) & IRQ_EN;
  assign is_load   = (CU_OPCODE == OP_LOAD);
  assign irq_rise  = IRQ & ~irq_prev;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    IRQ_ID = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) IRQ_ID = ID_W'(i);
    end
  end

  // Output decode, purely combinational from state, counter, opcode and pending.
  always_comb begin
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    IRQ_ACK   = '0;
    case (state)
      ST_FETCH: MEM_RDEN1 = (cnt == 3'd0);
      ST_EXEC: begin
        case (CU_OPCODE)
          OP_LOAD:   MEM_RDEN2 = 1'b1;
          OP_STORE: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = 1'b1;
          end
          OP_BRANCH: PC_WRITE = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
          end
          OP_SYSTEM: begin
            PC_WRITE = 1'b1;
            // Only csrrw writes a GPR and a CSR; every other funct3 is treated as mret.
            if (FUNC3 == 3'b001) begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
            end
          end
          default:   PC_WRITE = 1'b1;
        endcase
      end
      ST_WB: begin
        PC_WRITE  = wait_done;
        REG_WRITE = wait_done;
      end
      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        CSR_WE    = 1'b1;
        // Masked by pending so an empty pending vector can never ack line 0.
        IRQ_ACK   = pending & (NUM_IRQ'(1) << IRQ_ID);
      end
      default: ;
    endcase
  end

  // Next state; the counter defaults to zero so every state entry starts a fresh count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 3'd0;
    case (state)
      ST_FETCH: begin
        if (wait_done) state_nxt = ST_EXEC;
        else           cnt_nxt   = cnt + 3'd1;
      end
      ST_EXEC: begin
        if (is_load)     state_nxt = ST_WB;
        else if (irq_go) state_nxt = ST_INTR;
        else             state_nxt = ST_FETCH;
      end
      ST_WB: begin
        if (!wait_done)  cnt_nxt   = cnt + 3'd1;
        else if (irq_go) state_nxt = ST_INTR;
        else             state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_FETCH;
      cnt      <= 3'd0;
      pending  <= '0;
      irq_prev <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      irq_prev <= IRQ;
      // A new rising edge on the line being acked survives the ack.
      pending  <= (pending & ~IRQ_ACK) | irq_rise;
    end
  end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Parametrised multicycle control-unit state machine for the OTTER RISC-V core. It sequences instruction fetch, execute and load writeback, and inserts a configurable number of memory wait states. It latches up to NUM_IRQ edge-triggered interrupt lines and takes them by fixed priority between instructions. It sits beside the combinational decoder, which still produces ALU_FUN, ALU_SRCA/B, RF_WR_SEL and PC_SOURCE. This block owns every write enable and the INT_TAKEN signal that drives that decoder.

## Interface
- NUM_IRQ, 4: number of interrupt lines, legal 1..8.
- MEM_WAIT, 1: extra memory wait cycles after a read request, legal 0..7.
- ID_W, derived: max(1, $clog2(NUM_IRQ)); not overridable.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset; asynchronous assertion, active-low.
- CU_OPCODE  in  7  instruction opcode from the IR.
- FUNC3  in  3  instruction funct3 from the IR.
- IRQ  in  NUM_IRQ  interrupt request lines, synchronous to CLK, level.
- IRQ_EN  in  1  global interrupt enable (mstatus.MIE).
- PC_WRITE  out  1  PC register load enable.
- REG_WRITE  out  1  register-file write enable.
- MEM_RDEN1  out  1  instruction-memory read request.
- MEM_RDEN2  out  1  data-memory read request.
- MEM_WE2  out  1  data-memory write enable.
- CSR_WE  out  1  CSR write enable.
- INT_TAKEN  out  1  interrupt entry; forces PC_SOURCE=4 in the decoder.
- IRQ_ID  out  ID_W  index of the highest-priority pending line.
- IRQ_ACK  out  NUM_IRQ  one-hot acknowledge of the line being taken.

## Operation
- States: FETCH, EXEC, WB, INTR. A wait counter (3 bits) runs in FETCH and WB.
- FETCH
  - MEM_RDEN1=1 on the first cycle only.
  - State lasts 1+MEM_WAIT cycles, then goes to EXEC.
- EXEC lasts one cycle. Outputs depend on opcode:
  - LOAD (0000011): MEM_RDEN2=1; next state WB.
  - STORE (0100011): MEM_WE2=1, PC_WRITE=1.
  - BRANCH (1100011): PC_WRITE=1.
  - LUI, AUIPC, JAL, JALR, OP_IMM, OP: PC_WRITE=1, REG_WRITE=1.
  - SYSTEM (1110011) with FUNC3=001: PC_WRITE=1, REG_WRITE=1, CSR_WE=1.
  - SYSTEM with any other FUNC3 (mret): PC_WRITE=1.
  - Any other opcode: PC_WRITE=1 only; the instruction is a NOP.
  - For every non-LOAD opcode, next state is INTR if (pending & IRQ_EN) is nonzero, else FETCH.
- WB
  - State lasts 1+MEM_WAIT cycles.
  - PC_WRITE=1 and REG_WRITE=1 on the final cycle only.
  - Next state is INTR or FETCH, using the same rule as EXEC, evaluated on the final cycle.
- INTR lasts one cycle.
  - INT_TAKEN=1, PC_WRITE=1, CSR_WE=1 (mepc/mcause save).
  - IRQ_ACK=one-hot(IRQ_ID).
  - Next state is FETCH.
- Interrupt capture:
  - irq_prev register holds the previous IRQ value; rise = IRQ & ~irq_prev.
  - pending <= (pending & ~IRQ_ACK) | rise. A set wins over an ack on the same line and cycle.
  - pending is held while IRQ_EN=0; it is not lost.
- Priority: IRQ_ID is the lowest set index of pending. It is 0 when none is pending.
- Every output not listed for a state is 0.

## Timing
- Reset values:
  - State = FETCH, counter = 0, pending = 0, irq_prev = 0.
  - Outputs follow from the FETCH state: MEM_RDEN1=1, all other enables 0, IRQ_ID=0, IRQ_ACK=0.
- Releasing RST_N mid-operation always restarts in FETCH. Any in-flight load or writeback is abandoned.
- Outputs are combinational from state, counter, opcode and pending. No output register stage.
- Latency per instruction:
  - Non-load: 2+MEM_WAIT cycles.
  - Load: 3+2·MEM_WAIT cycles.
  - Taken interrupt: +1 cycle.
- Interrupt timing:
  - A rising IRQ edge sampled at cycle n is pending from cycle n+1.
  - An edge in the same cycle as the EXEC decision does not divert that instruction; it is taken at the next boundary.
  - IRQ_EN is sampled combinationally in the EXEC or final WB cycle.
- Counter rules:
  - Counter clears on every state entry.
  - No wrap is possible: the terminal count is MEM_WAIT ≤ 7.

## Test plan
- Reset: RST_N=0 asynchronously mid-WB → state FETCH immediately; MEM_RDEN1=1, all other enables 0, IRQ_ACK=0. After release, the fetch restarts.
- ALU op, MEM_WAIT=0, CU_OPCODE=0110011:
  - Cycle 0 FETCH, MEM_RDEN1=1.
  - Cycle 1 EXEC, PC_WRITE=REG_WRITE=1.
  - Cycle 2 FETCH.
- Load, MEM_WAIT=2:
  - FETCH for 3 cycles, with MEM_RDEN1 high only in the first.
  - EXEC with MEM_RDEN2=1.
  - WB for 3 cycles, with PC_WRITE=REG_WRITE=1 only in the third.
  - 7 cycles total.
- Priority, NUM_IRQ=4, IRQ_EN=1: IRQ=0110 rises during FETCH of an OP →
  - After EXEC, INTR with IRQ_ID=1, IRQ_ACK=0010, INT_TAKEN=1.
  - At the next boundary, INTR with IRQ_ID=2, IRQ_ACK=0100.
- Masking: IRQ_EN=0, IRQ[3] pulses for 1 cycle → no INTR over 3 instructions. After IRQ_EN=1, the next boundary enters INTR with IRQ_ID=3.
- Ack/set collision: IRQ[0] re-rises in the INTR cycle acking line 0 → pending[0] remains set; a second INTR with IRQ_ID=0 follows the next instruction.
